gray_code_checker: RTL

- Sits directly downstream of the gray-code adder/encoder stage and consumes its valid-qualified gray word stream.
- Decodes each gray word to binary and checks every consecutive valid pair for a legal +1 step: exactly one bit flipped, and binary advanced by 1 modulo 2^WIDTH.
- Reports per-sample errors, a sticky flag, a saturating error count, and the first failing word; replaces bench-side checking in the same design.

---
 rtl/gray_code_pkg.sv | 36 +++
 rtl/gray_code_checker_gray_to_binary.sv | 53 +++++
 rtl/gray_code_checker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gray_code_pkg.sv
// Shared types and helpers for the gray-code checker and anything that
// produces or consumes the encoder's gray stream.
package gray_code_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 32;
  // Helpers operate on a fixed wide word; callers zero-extend narrower data.
  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin_to_gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_W-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_code_checker_gray_to_binary.sv
// Registered gray-to-binary decode stage; carries the raw gray word and a
// one-bit sideband tag alongside the decoded value.
module gray_to_binary #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_gray,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_tag
);

  logic [WIDTH-1:0] w_bin;
  logic             r_valid;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_bin;
  logic             r_tag;

  // Each binary bit is the XOR of all gray bits at or above it, so no
  // ripple chain is needed between bits.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign w_bin[gi] = ^i_gray[WIDTH-1:gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_gray  <= '0;
      r_bin   <= '0;
      r_tag   <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_tag   <= i_valid & i_tag;
      if (i_valid) begin
        r_gray <= i_gray;
        r_bin  <= w_bin;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_gray  = r_gray;
  assign o_bin   = r_bin;
  assign o_tag   = r_tag;

endmodule

// File: rtl/gray_code_checker.sv
// Checks that a valid-qualified gray stream advances by exactly +1 per
// sample; reports per-sample errors, sticky flag, counts and first bad word.
module gray_code_checker
  import gray_code_pkg::*;
#(
  parameter int WIDTH     = GRAY_WIDTH_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 gray_valid,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 resync,
  output logic                 bin_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_error,
  output logic                 error_sticky,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [WIDTH-1:0]     first_error_gray
);

  // A resync seen on an invalid cycle is held until the next valid sample.
  logic r_resync_pend;
  logic w_resync_req;

  assign w_resync_req = resync | r_resync_pend;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_resync_pend <= 1'b0;
    end else if (gray_valid) begin
      r_resync_pend <= 1'b0;
    end else if (resync) begin
      r_resync_pend <= 1'b1;
    end
  end

  logic             w_s1_valid;
  logic [WIDTH-1:0] w_s1_gray;
  logic [WIDTH-1:0] w_s1_bin;
  logic             w_s1_resync;

  gray_to_binary #(
    .WIDTH(WIDTH)
  ) u_s1 (
    .clock  (clock),
    .reset  (reset),
    .i_valid(gray_valid),
    .i_gray (gray_in),
    .i_tag  (w_resync_req),
    .o_valid(w_s1_valid),
    .o_gray (w_s1_gray),
    .o_bin  (w_s1_bin),
    .o_tag  (w_s1_resync)
  );

  state_t               r_state;
  logic [WIDTH-1:0]     r_prev_gray;
  logic [WIDTH-1:0]     r_prev_bin;
  logic                 r_bin_valid;
  logic [WIDTH-1:0]     r_bin_out;
  logic                 r_step_error;
  logic                 r_sticky;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0] r_smp_cnt;
  logic [WIDTH-1:0]     r_first_err;

  state_t               w_state_next;
  logic [WIDTH-1:0]     w_prev_gray_next;
  logic [WIDTH-1:0]     w_prev_bin_next;
  logic                 w_bin_valid_next;
  logic [WIDTH-1:0]     w_bin_out_next;
  logic                 w_step_error_next;
  logic                 w_sticky_next;
  logic [CNT_WIDTH-1:0] w_err_cnt_next;
  logic [CNT_WIDTH-1:0] w_smp_cnt_next;
  logic [WIDTH-1:0]     w_first_err_next;
  logic                 w_fail;

  logic [6:0]       w_dist;
  logic [WIDTH-1:0] w_prev_inc;
  logic             w_step_ok;

  assign w_dist     = popcount(MAX_W'(w_s1_gray ^ r_prev_gray));
  assign w_prev_inc = r_prev_bin + WIDTH'(1);
  assign w_step_ok  = (w_dist == 7'd1) && (w_s1_bin == w_prev_inc);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_prev_gray  <= '0;
      r_prev_bin   <= '0;
      r_bin_valid  <= 1'b0;
      r_bin_out    <= '0;
      r_step_error <= 1'b0;
      r_sticky     <= 1'b0;
      r_err_cnt    <= '0;
      r_smp_cnt    <= '0;
      r_first_err  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_prev_gray  <= w_prev_gray_next;
      r_prev_bin   <= w_prev_bin_next;
      r_bin_valid  <= w_bin_valid_next;
      r_bin_out    <= w_bin_out_next;
      r_step_error <= w_step_error_next;
      r_sticky     <= w_sticky_next;
      r_err_cnt    <= w_err_cnt_next;
      r_smp_cnt    <= w_smp_cnt_next;
      r_first_err  <= w_first_err_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_prev_gray_next  = r_prev_gray;
    w_prev_bin_next   = r_prev_bin;
    w_bin_valid_next  = 1'b0;
    w_bin_out_next    = r_bin_out;
    w_step_error_next = 1'b0;
    w_sticky_next     = r_sticky;
    w_err_cnt_next    = r_err_cnt;
    w_smp_cnt_next    = r_smp_cnt;
    w_first_err_next  = r_first_err;
    w_fail            = 1'b0;

    if (w_s1_valid) begin
      w_bin_valid_next = 1'b1;
      w_bin_out_next   = w_s1_bin;
      w_prev_gray_next = w_s1_gray;
      w_prev_bin_next  = w_s1_bin;
      w_state_next     = TRACK;
      if (!(&r_smp_cnt)) begin
        w_smp_cnt_next = r_smp_cnt + CNT_WIDTH'(1);
      end

      unique case (r_state)
        IDLE:    w_fail = 1'b0;
        TRACK:   w_fail = !w_s1_resync && !w_step_ok;
        default: w_fail = 1'b0;
      endcase

      if (w_fail) begin
        w_step_error_next = 1'b1;
        w_sticky_next     = 1'b1;
        if (!(&r_err_cnt)) begin
          w_err_cnt_next = r_err_cnt + CNT_WIDTH'(1);
        end
        if (!r_sticky) begin
          w_first_err_next = w_s1_gray;
        end
      end
    end
  end

  assign bin_valid        = r_bin_valid;
  assign bin_out          = r_bin_out;
  assign step_error       = r_step_error;
  assign error_sticky     = r_sticky;
  assign error_count      = r_err_cnt;
  assign sample_count     = r_smp_cnt;
  assign first_error_gray = r_first_err;

endmodule
